// File: rtl/unidade_escrita_br_pkg.sv
// Shared definitions for the register-bank write-back stage: data source codes
// and FSM state encoding.
package unidade_escrita_br_pkg;

  localparam logic [1:0] SEL_LINK = 2'b00;
  localparam logic [1:0] SEL_ULA  = 2'b01;
  localparam logic [1:0] SEL_MEM  = 2'b10;
  localparam logic [1:0] SEL_ENT  = 2'b11;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    ESPERA_MEM = 2'd1,
    ESPERA_ENT = 2'd2
  } estado_t;

  // Register 0 is protected when zero_ro is set.
  function automatic logic destino_protegido(input logic zero_ro, input logic is_zero);
    return zero_ro & is_zero;
  endfunction

endpackage

// File: rtl/unidade_escrita_br_if.sv
// Request/response bundle between the core and the write-back stage.
interface unidade_escrita_br_if #(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 26,
  parameter int REG_ADDR_W = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_sel;
  logic [REG_ADDR_W-1:0] req_dest;
  logic [PC_W-1:0]       PC;
  logic [DATA_W-1:0]     ULA;
  logic [DATA_W-1:0]     memoria_dados;
  logic                  memoria_valid;
  logic [DATA_W-1:0]     entrada_dados;
  logic                  entrada_valid;
  logic                  entrada_ack;
  logic                  stall;
  logic                  br_we;
  logic [REG_ADDR_W-1:0] br_addr;
  logic [DATA_W-1:0]     br_dado;
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0]     fwd_dado;

  modport master (
    output req_valid, req_sel, req_dest, PC, ULA, memoria_dados, memoria_valid,
           entrada_dados, entrada_valid,
    input  req_ready, entrada_ack, stall, br_we, br_addr, br_dado,
           fwd_valid, fwd_addr, fwd_dado
  );

  modport slave (
    input  req_valid, req_sel, req_dest, PC, ULA, memoria_dados, memoria_valid,
           entrada_dados, entrada_valid,
    output req_ready, entrada_ack, stall, br_we, br_addr, br_dado,
           fwd_valid, fwd_addr, fwd_dado
  );
endinterface

// File: rtl/unidade_escrita_br_seletor.sv
// Combinational 4:1 write-data select; the link source is the zero-extended
// PC plus LINK_INC, wrapping modulo 2^DATA_W.
module seletor_fonte_br
  import unidade_escrita_br_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 26,
  parameter int LINK_INC = 1
) (
  input  logic [1:0]        sel,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] ula,
  input  logic [DATA_W-1:0] memoria,
  input  logic [DATA_W-1:0] entrada,
  output logic [DATA_W-1:0] dado
);

  logic [DATA_W-1:0] link_s;

  assign link_s = DATA_W'(pc) + DATA_W'(LINK_INC);

  // Source multiplexer
  always_comb begin
    dado = {DATA_W{1'b0}};
    case (sel)
      SEL_LINK: dado = link_s;
      SEL_ULA:  dado = ula;
      SEL_MEM:  dado = memoria;
      SEL_ENT:  dado = entrada;
      default:  dado = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/unidade_escrita_br.sv
// Write-back stage: accepts one request, waits on memory/input handshakes while
// stalling the core, then issues a registered single-cycle register-bank write.
module unidade_escrita_br
  import unidade_escrita_br_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 26,
  parameter int REG_ADDR_W = 5,
  parameter int LINK_INC   = 1,
  parameter bit ZERO_RO    = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  unidade_escrita_br_if.slave  bus
);

  estado_t               estado_r, estado_prox_s;
  logic [REG_ADDR_W-1:0] dest_r, dest_s;
  logic [1:0]            sel_s;
  logic                  escreve_s, ack_s, grava_s;
  logic [DATA_W-1:0]     dado_sel_s;

  logic                  br_we_r, ack_r, fwd_valid_r;
  logic [REG_ADDR_W-1:0] br_addr_r;
  logic [DATA_W-1:0]     br_dado_r;

  seletor_fonte_br #(
    .DATA_W   (DATA_W),
    .PC_W     (PC_W),
    .LINK_INC (LINK_INC)
  ) u_seletor (
    .sel     (sel_s),
    .pc      (bus.PC),
    .ula     (bus.ULA),
    .memoria (bus.memoria_dados),
    .entrada (bus.entrada_dados),
    .dado    (dado_sel_s)
  );

  // Next-state, write strobe and source selection
  always_comb begin
    estado_prox_s = estado_r;
    dest_s        = dest_r;
    sel_s         = bus.req_sel;
    escreve_s     = 1'b0;
    ack_s         = 1'b0;
    case (estado_r)
      OCIOSO: begin
        if (bus.req_valid) begin
          dest_s = bus.req_dest;
          case (bus.req_sel)
            SEL_MEM: begin
              if (bus.memoria_valid) begin
                escreve_s = 1'b1;
              end else begin
                estado_prox_s = ESPERA_MEM;
              end
            end
            SEL_ENT: begin
              if (bus.entrada_valid) begin
                escreve_s = 1'b1;
                ack_s     = 1'b1;
              end else begin
                estado_prox_s = ESPERA_ENT;
              end
            end
            default: escreve_s = 1'b1;
          endcase
        end else begin
          estado_prox_s = OCIOSO;
        end
      end
      ESPERA_MEM: begin
        sel_s = SEL_MEM;
        if (bus.memoria_valid) begin
          escreve_s     = 1'b1;
          estado_prox_s = OCIOSO;
        end else begin
          estado_prox_s = ESPERA_MEM;
        end
      end
      ESPERA_ENT: begin
        sel_s = SEL_ENT;
        if (bus.entrada_valid) begin
          escreve_s     = 1'b1;
          ack_s         = 1'b1;
          estado_prox_s = OCIOSO;
        end else begin
          estado_prox_s = ESPERA_ENT;
        end
      end
      default: estado_prox_s = OCIOSO;
    endcase
  end

  assign grava_s = escreve_s &
                   ~destino_protegido(ZERO_RO, dest_s == {REG_ADDR_W{1'b0}});

  // State and output registers; write data is captured in the capture cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r    <= OCIOSO;
      dest_r      <= {REG_ADDR_W{1'b0}};
      br_we_r     <= 1'b0;
      ack_r       <= 1'b0;
      fwd_valid_r <= 1'b0;
      br_addr_r   <= {REG_ADDR_W{1'b0}};
      br_dado_r   <= {DATA_W{1'b0}};
    end else begin
      estado_r <= estado_prox_s;
      dest_r   <= dest_s;
      br_we_r  <= grava_s;
      ack_r    <= ack_s;
      if (grava_s) begin
        br_addr_r   <= dest_s;
        br_dado_r   <= dado_sel_s;
        fwd_valid_r <= 1'b1;
      end
    end
  end

  assign bus.req_ready   = (estado_r == OCIOSO);
  assign bus.stall       = (estado_r != OCIOSO);
  assign bus.br_we       = br_we_r;
  assign bus.br_addr     = br_addr_r;
  assign bus.br_dado     = br_dado_r;
  assign bus.entrada_ack = ack_r;
  // The forwarding copy is by definition the last committed write.
  assign bus.fwd_valid   = fwd_valid_r;
  assign bus.fwd_addr    = br_addr_r;
  assign bus.fwd_dado    = br_dado_r;

endmodule

// File: tb/tb_unidade_escrita_br.sv
// Self-checking bench: directed scenarios plus randomized requests compared
// against a transaction-level model of the write-back rules.
module tb_unidade_escrita_br;
  import unidade_escrita_br_pkg::*;

  localparam int DW = 32;
  localparam int PW = 26;
  localparam int AW = 5;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  unidade_escrita_br_if #(.DATA_W(DW), .PC_W(PW), .REG_ADDR_W(AW)) bus ();
  unidade_escrita_br_if #(.DATA_W(26), .PC_W(26), .REG_ADDR_W(AW)) bw ();

  unidade_escrita_br #(.DATA_W(DW), .PC_W(PW), .REG_ADDR_W(AW), .LINK_INC(1), .ZERO_RO(1'b1))
    dut (.clock(clock), .reset(reset), .bus(bus));
  unidade_escrita_br #(.DATA_W(26), .PC_W(26), .REG_ADDR_W(AW), .LINK_INC(1), .ZERO_RO(1'b1))
    dut_w (.clock(clock), .reset(reset), .bus(bw));

  int n_chk = 0;
  int n_pass = 0;

  // Model of the architecturally visible write state
  logic [AW-1:0] m_addr;
  logic [63:0]   m_dado;
  logic          m_fwd;

  function automatic logic [63:0] ref_dado(input logic [1:0] sel, input logic [63:0] pc,
                                           input logic [63:0] ula, input logic [63:0] mem,
                                           input logic [63:0] ent, input int dw);
    logic [63:0] r;
    case (sel)
      2'b00:   r = pc + 64'd1;
      2'b01:   r = ula;
      2'b10:   r = mem;
      default: r = ent;
    endcase
    return r % (64'd1 << dw);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_outs(input string tag, input logic we, input logic ack, input logic st);
    chk({tag, ".br_we"}, bus.br_we, we);
    chk({tag, ".ack"}, bus.entrada_ack, ack);
    chk({tag, ".stall"}, bus.stall, st);
    chk({tag, ".ready"}, bus.req_ready, !st);
    chk({tag, ".br_addr"}, bus.br_addr, m_addr);
    chk({tag, ".br_dado"}, bus.br_dado, m_dado);
    chk({tag, ".fwd_valid"}, bus.fwd_valid, m_fwd);
    chk({tag, ".fwd_addr"}, bus.fwd_addr, m_addr);
    chk({tag, ".fwd_dado"}, bus.fwd_dado, m_dado);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_write(input logic [AW-1:0] dest, input logic [63:0] d, output logic we);
    we = (dest != '0);
    if (we) begin
      m_addr = dest;
      m_dado = d;
      m_fwd  = 1'b1;
    end
  endtask

  // One complete request; dly = cycles the memory/input valid arrives late
  task automatic run_req(input string tag, input logic [1:0] sel, input logic [AW-1:0] dest,
                         input logic [PW-1:0] pc, input logic [DW-1:0] ula,
                         input logic [DW-1:0] mem, input logic [DW-1:0] ent, input int delay);
    int dly;
    logic we_e;
    dly = (sel == SEL_MEM || sel == SEL_ENT) ? delay : 0;
    chk({tag, ".pre_ready"}, bus.req_ready, 1'b1);
    bus.req_valid     = 1'b1;
    bus.req_sel       = sel;
    bus.req_dest      = dest;
    bus.PC            = pc;
    bus.ULA           = ula;
    bus.memoria_dados = mem;
    bus.entrada_dados = ent;
    bus.memoria_valid = (sel == SEL_MEM) ? (dly == 0) : (sel != SEL_ENT && $urandom_range(1) == 1);
    bus.entrada_valid = (sel == SEL_ENT) ? (dly == 0) : (sel != SEL_MEM && $urandom_range(1) == 1);
    step();
    bus.req_valid = 1'b0;
    if (sel != SEL_MEM) bus.memoria_valid = 1'b0;
    if (sel != SEL_ENT) bus.entrada_valid = 1'b0;
    for (int i = 0; i < dly; i++) begin
      chk({tag, ".wait_stall"}, bus.stall, 1'b1);
      chk({tag, ".wait_we"}, bus.br_we, 1'b0);
      if (i == dly - 1) begin
        if (sel == SEL_MEM) bus.memoria_valid = 1'b1;
        else bus.entrada_valid = 1'b1;
      end
      step();
    end
    bus.memoria_valid = 1'b0;
    bus.entrada_valid = 1'b0;
    model_write(dest, ref_dado(sel, 64'(pc), 64'(ula), 64'(mem), 64'(ent), DW), we_e);
    chk_outs({tag, ".wr"}, we_e, sel == SEL_ENT, 1'b0);
    step();
    chk_outs({tag, ".after"}, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic we_e;
    bus.req_valid = 1'b0; bus.req_sel = 2'b00; bus.req_dest = '0; bus.PC = '0; bus.ULA = '0;
    bus.memoria_dados = '0; bus.memoria_valid = 1'b0; bus.entrada_dados = '0; bus.entrada_valid = 1'b0;
    bw.req_valid = 1'b0; bw.req_sel = 2'b00; bw.req_dest = '0; bw.PC = '0; bw.ULA = '0;
    bw.memoria_dados = '0; bw.memoria_valid = 1'b0; bw.entrada_dados = '0; bw.entrada_valid = 1'b0;
    m_addr = '0; m_dado = '0; m_fwd = 1'b0;

    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk_outs("reset", 1'b0, 1'b0, 1'b0);

    // Back-to-back ULA then link
    bus.req_valid = 1'b1; bus.req_sel = SEL_ULA; bus.req_dest = 5'd3; bus.ULA = 32'h12345678;
    step();
    model_write(5'd3, 64'h12345678, we_e);
    chk_outs("b2b1", 1'b1, 1'b0, 1'b0);
    bus.req_sel = SEL_LINK; bus.req_dest = 5'd31; bus.PC = 26'h0000010;
    step();
    bus.req_valid = 1'b0;
    model_write(5'd31, 64'h11, we_e);
    chk_outs("b2b2", 1'b1, 1'b0, 1'b0);
    step();
    chk_outs("b2b_end", 1'b0, 1'b0, 1'b0);

    run_req("mem_late4", SEL_MEM, 5'd7, '0, '0, 32'hDEADBEEF, '0, 4);
    run_req("ent_late10", SEL_ENT, 5'd5, '0, '0, '0, 32'h0000002A, 10);
    run_req("zero_ula", SEL_ULA, 5'd0, '0, 32'h000000FF, '0, '0, 0);
    run_req("zero_ent", SEL_ENT, 5'd0, '0, '0, '0, 32'h00000055, 2);

    // Stray valids while idle are ignored
    bus.memoria_valid = 1'b1; bus.entrada_valid = 1'b1;
    step();
    bus.memoria_valid = 1'b0; bus.entrada_valid = 1'b0;
    chk_outs("stray", 1'b0, 1'b0, 1'b0);

    // Reset while waiting on memory abandons the request
    bus.req_valid = 1'b1; bus.req_sel = SEL_MEM; bus.req_dest = 5'd9; bus.memoria_dados = 32'hCAFEF00D;
    step();
    bus.req_valid = 1'b0;
    step();
    chk("rst_mid.stall", bus.stall, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_addr = '0; m_dado = '0; m_fwd = 1'b0;
    bus.memoria_valid = 1'b1;
    step();
    bus.memoria_valid = 1'b0;
    chk_outs("rst_mid", 1'b0, 1'b0, 1'b0);
    run_req("post_rst", SEL_ULA, 5'd12, '0, 32'h0BADC0DE, '0, '0, 0);

    for (int k = 0; k < 24; k++) begin
      run_req("rand", 2'($urandom_range(3)), AW'($urandom_range(31)), PW'($urandom),
              32'($urandom), 32'($urandom), 32'($urandom), int'($urandom_range(3)));
    end

    // 26-bit instance: link wraps to zero
    bw.req_valid = 1'b1; bw.req_sel = SEL_LINK; bw.req_dest = 5'd4; bw.PC = 26'h3FFFFFF;
    step();
    bw.req_valid = 1'b0;
    chk("wrap.we", bw.br_we, 1'b1);
    chk("wrap.addr", bw.br_addr, 64'd4);
    chk("wrap.dado", bw.br_dado, ref_dado(SEL_LINK, 64'h3FFFFFF, '0, '0, '0, 26));
    step();
    chk("wrap.we_end", bw.br_we, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
